// File: rtl/dec_to_hex.sv
// Sequential decimal-to-binary converter: rebuilds a 16-bit sum and an 8-bit count
// from BCD-style digit bytes using Horner iteration, one digit per clock.
module dec_to_hex #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0][7:0] dec_i,
  input  logic [2:0][7:0] n_dec_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [15:0]     hex_o,
  output logic [7:0]      n_hex_o,
  output logic            ovf_o,
  output logic            n_ovf_o,
  output logic            err_o,
  output logic            valid_o,
  input  logic            ready_i
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e          state_q, state_d;
  logic [4:0][7:0] dig_q, dig_d;
  logic [2:0][7:0] n_dig_q, n_dig_d;
  logic [16:0]     acc_q, acc_d;
  logic [9:0]      n_acc_q, n_acc_d;
  logic [2:0]      idx_q, idx_d;
  logic            err_q, err_d;
  logic [15:0]     hex_q, hex_d;
  logic [7:0]      n_hex_q, n_hex_d;
  logic            ovf_q, ovf_d;
  logic            n_ovf_q, n_ovf_d;
  logic            res_err_q, res_err_d;

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign hex_o   = hex_q;
  assign n_hex_o = n_hex_q;
  assign ovf_o   = ovf_q;
  assign n_ovf_o = n_ovf_q;
  assign err_o   = res_err_q;

  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    n_dig_d   = n_dig_q;
    acc_d     = acc_q;
    n_acc_d   = n_acc_q;
    idx_d     = idx_q;
    err_d     = err_q;
    hex_d     = hex_q;
    n_hex_d   = n_hex_q;
    ovf_d     = ovf_q;
    n_ovf_d   = n_ovf_q;
    res_err_d = res_err_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          dig_d   = dec_i;
          n_dig_d = n_dec_i;
          acc_d   = '0;
          n_acc_d = '0;
          idx_d   = 3'd4;
          err_d   = 1'b0;
          state_d = CONV;
        end
      end

      CONV: begin
        // Digits are range-checked on the full byte, but only the low nibble feeds the sum.
        acc_d = acc_q * 17'd10 + 17'(dig_q[idx_q][3:0]);
        err_d = err_q | (dig_q[idx_q] > 8'd9);
        if (idx_q <= 3'd2) begin
          n_acc_d = n_acc_q * 10'd10 + 10'(n_dig_q[idx_q[1:0]][3:0]);
          err_d   = err_d | (n_dig_q[idx_q[1:0]] > 8'd9);
        end
        idx_d = idx_q - 3'd1;

        if (idx_q == 3'd0) begin
          state_d = DONE;
          if (err_d) begin
            hex_d     = '0;
            n_hex_d   = '0;
            ovf_d     = 1'b0;
            n_ovf_d   = 1'b0;
            res_err_d = 1'b1;
          end else begin
            res_err_d = 1'b0;
            if (acc_d > 17'd65535) begin
              ovf_d = 1'b1;
              hex_d = SAT_EN ? 16'hFFFF : acc_d[15:0];
            end else begin
              ovf_d = 1'b0;
              hex_d = acc_d[15:0];
            end
            if (n_acc_d > 10'd255) begin
              n_ovf_d = 1'b1;
              n_hex_d = SAT_EN ? 8'hFF : n_acc_d[7:0];
            end else begin
              n_ovf_d = 1'b0;
              n_hex_d = n_acc_d[7:0];
            end
          end
        end
      end

      DONE: begin
        if (ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      dig_q     <= '0;
      n_dig_q   <= '0;
      acc_q     <= '0;
      n_acc_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      hex_q     <= '0;
      n_hex_q   <= '0;
      ovf_q     <= 1'b0;
      n_ovf_q   <= 1'b0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      n_dig_q   <= n_dig_d;
      acc_q     <= acc_d;
      n_acc_q   <= n_acc_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      hex_q     <= hex_d;
      n_hex_q   <= n_hex_d;
      ovf_q     <= ovf_d;
      n_ovf_q   <= n_ovf_d;
      res_err_q <= res_err_d;
    end
  end

endmodule

// File: tb/tb_dec_to_hex.sv
// Scoreboard bench for dec_to_hex: one saturating and one wrapping instance share all inputs,
// expected results are queued at stimulus time and popped by a monitor on each transfer.
module tb_dec_to_hex;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [4:0][7:0] dec_i;
  logic [2:0][7:0] n_dec_i;
  logic            valid_i;
  logic            ready_i;

  logic            ready_o, valid_o, ovf_o, n_ovf_o, err_o;
  logic [15:0]     hex_o;
  logic [7:0]      n_hex_o;
  logic            readyW, validW, ovfW, nOvfW, errW;
  logic [15:0]     hexW;
  logic [7:0]      nHexW;

  typedef struct packed {
    logic [15:0] hexSat;
    logic [15:0] hexWrap;
    logic [7:0]  nSat;
    logic [7:0]  nWrap;
    logic        ovf;
    logic        nOvf;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dec_to_hex #(.SAT_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .dec_i(dec_i), .n_dec_i(n_dec_i), .valid_i(valid_i),
    .ready_o(ready_o), .hex_o(hex_o), .n_hex_o(n_hex_o), .ovf_o(ovf_o), .n_ovf_o(n_ovf_o),
    .err_o(err_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  dec_to_hex #(.SAT_EN(1'b0)) dutWrap (
    .clk_i(clk), .rst_i(rst_i), .dec_i(dec_i), .n_dec_i(n_dec_i), .valid_i(valid_i),
    .ready_o(readyW), .hex_o(hexW), .n_hex_o(nHexW), .ovf_o(ovfW), .n_ovf_o(nOvfW),
    .err_o(errW), .valid_o(validW), .ready_i(ready_i)
  );

  function automatic exp_t mkExp(input int hs, input int hw, input int ns, input int nw,
                                 input bit ovf, input bit nOvf, input bit err);
    exp_t e;
    e.hexSat  = 16'(hs);
    e.hexWrap = 16'(hw);
    e.nSat    = 8'(ns);
    e.nWrap   = 8'(nw);
    e.ovf     = ovf;
    e.nOvf    = nOvf;
    e.err     = err;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got valid_o=1 with empty scoreboard (t=%0t)", $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("hex_sat",    hex_o,   e.hexSat);
        checkOutput("n_hex_sat",  n_hex_o, e.nSat);
        checkOutput("ovf_sat",    ovf_o,   e.ovf);
        checkOutput("n_ovf_sat",  n_ovf_o, e.nOvf);
        checkOutput("err_sat",    err_o,   e.err);
        checkOutput("valid_wrap", validW,  1);
        checkOutput("hex_wrap",   hexW,    e.hexWrap);
        checkOutput("n_hex_wrap", nHexW,   e.nWrap);
        checkOutput("ovf_wrap",   ovfW,    e.ovf);
        checkOutput("n_ovf_wrap", nOvfW,   e.nOvf);
        checkOutput("err_wrap",   errW,    e.err);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic applyStimulus(input logic [4:0][7:0] d, input logic [2:0][7:0] nd,
                               input exp_t e, input bit push);
    int waited = 0;
    dec_i   = d;
    n_dec_i = nd;
    valid_i = 1'b1;
    if (push) expQ.push_back(e);
    while (!ready_o && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ready_o) begin
      checkOutput("accept_timeout", 32'(ready_o), 1);
      valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic waitValid();
    int waited = 0;
    while (!valid_o && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("valid_seen", 32'(valid_o), 1);
  endtask

  task automatic waitReady();
    int waited = 0;
    while (!ready_o && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("ready_seen", 32'(ready_o), 1);
  endtask

  initial begin
    int v, c;
    logic [4:0][7:0] d;
    logic [2:0][7:0] nd;

    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    dec_i   = '0;
    n_dec_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(ready_o), 1);
    rst_i = 1'b0;
    checkOutput("reset_valid", 32'(valid_o), 0);
    checkOutput("reset_hex",   hex_o, 0);
    checkOutput("reset_n_hex", n_hex_o, 0);
    checkOutput("reset_flags", {ovf_o, n_ovf_o, err_o}, 0);

    // Basic conversion with latency and ready_o profile.
    applyStimulus({8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, {8'd0, 8'd4, 8'd2},
                  mkExp(16'h3039, 16'h3039, 8'h2A, 8'h2A, 0, 0, 0), 1);
    checkOutput("conv_ready_low", 32'(ready_o), 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checkOutput("conv_valid_low", 32'(valid_o), 0);
      checkOutput("conv_ready_low", 32'(ready_o), 0);
    end
    @(posedge clk); #1;
    checkOutput("latency_valid", 32'(valid_o), 1);
    checkOutput("done_ready_low", 32'(ready_o), 0);
    @(posedge clk); #1;
    checkOutput("xfer_valid_fall", 32'(valid_o), 0);
    checkOutput("xfer_ready_rise", 32'(ready_o), 1);

    // Boundaries and invalid digits.
    applyStimulus({8'd6, 8'd5, 8'd5, 8'd3, 8'd5}, {8'd2, 8'd5, 8'd5},
                  mkExp(16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 0, 0, 0), 1);
    applyStimulus({8'd6, 8'd5, 8'd5, 8'd3, 8'd6}, {8'd9, 8'd9, 8'd9},
                  mkExp(16'hFFFF, 16'h0000, 8'hFF, 8'hE7, 1, 1, 0), 1);
    applyStimulus({8'd9, 8'd9, 8'd9, 8'd9, 8'd9}, {8'd2, 8'd5, 8'd6},
                  mkExp(16'hFFFF, 16'h869F, 8'hFF, 8'h00, 1, 1, 0), 1);
    applyStimulus({8'd0, 8'd0, 8'h0A, 8'd0, 8'd0}, {8'd0, 8'd4, 8'd2},
                  mkExp(0, 0, 0, 0, 0, 0, 1), 1);
    applyStimulus({8'd1, 8'd2, 8'h13, 8'd4, 8'd5}, {8'd9, 8'd9, 8'd9},
                  mkExp(0, 0, 0, 0, 0, 0, 1), 1);
    applyStimulus({8'd0, 8'd0, 8'd1, 8'd2, 8'd3}, {8'd0, 8'h20, 8'd1},
                  mkExp(0, 0, 0, 0, 0, 0, 1), 1);

    // Backpressure: hold result, offer a second word during DONE.
    waitReady();
    ready_i = 1'b0;
    applyStimulus({8'd0, 8'd4, 8'd0, 8'd9, 8'd6}, {8'd1, 8'd2, 8'd8},
                  mkExp(16'h1000, 16'h1000, 8'h80, 8'h80, 0, 0, 0), 1);
    waitValid();
    dec_i   = {8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    n_dec_i = {8'd0, 8'd0, 8'd0};
    valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid_hold", 32'(valid_o), 1);
      checkOutput("bp_ready_low",  32'(ready_o), 0);
      checkOutput("bp_hex_hold",   hex_o, 16'h1000);
      checkOutput("bp_n_hex_hold", n_hex_o, 8'h80);
    end
    ready_i = 1'b1;
    applyStimulus({8'd9, 8'd9, 8'd9, 8'd9, 8'd9}, {8'd0, 8'd0, 8'd0},
                  mkExp(16'hFFFF, 16'h869F, 0, 0, 1, 0, 0), 1);

    // Reset on the third CONV edge aborts the word.
    waitReady();
    applyStimulus({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd2, 8'd3}, mkExp(0, 0, 0, 0, 0, 0, 0), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checkOutput("abort_ready", 32'(ready_o), 1);
    checkOutput("abort_valid", 32'(valid_o), 0);
    checkOutput("abort_hex",   hex_o, 0);
    checkOutput("abort_n_hex", n_hex_o, 0);
    checkOutput("abort_flags", {ovf_o, n_ovf_o, err_o}, 0);
    checkOutput("abort_wrap",  {hexW, nHexW, ovfW, nOvfW, errW}, 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_valid", 32'(valid_o), 0);
    end
    applyStimulus({8'd0, 8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd1},
                  mkExp(16'h0007, 16'h0007, 8'h01, 8'h01, 0, 0, 0), 1);

    // Round trip of random values through their decimal digits.
    for (int i = 0; i < 1000; i++) begin
      v  = int'($urandom_range(0, 65535));
      c  = int'($urandom_range(0, 255));
      d  = {8'(v / 10000), 8'((v / 1000) % 10), 8'((v / 100) % 10), 8'((v / 10) % 10), 8'(v % 10)};
      nd = {8'(c / 100), 8'((c / 10) % 10), 8'(c % 10)};
      applyStimulus(d, nd, mkExp(v, v, c, c, 0, 0, 0), 1);
    end

    for (int k = 0; k < 50 && expQ.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("queue_drained", 32'(expQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_to_hex.md
Name: dec_to_hex

Overview:
- Sequential decimal-to-binary converter. Inverse of the digit-split path.
- Accepts a 5-digit decimal sum word and a 3-digit decimal count word, one digit per byte.
- Rebuilds a 16-bit sum and an 8-bit count by Horner iteration (acc = acc*10 + digit), one digit per clock.
- Sits between the keypad/switch digit-entry logic and the arithmetic datapath. Uses valid/ready handshakes on both sides.

Parameters:
- SAT_EN, 1, 1 = saturate on overflow (sum to 16'hFFFF, count to 8'hFF); 0 = wrap to the low bits.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- dec_i  in  [4:0][7:0]  sum digits; [4]=ten-thousands ... [0]=units
- n_dec_i  in  [2:0][7:0]  count digits; [2]=hundreds ... [0]=units
- valid_i  in  1  input word valid
- ready_o  out  1  block can accept a word
- hex_o  out  16  binary sum
- n_hex_o  out  8  binary count
- ovf_o  out  1  sum value > 65535
- n_ovf_o  out  1  count value > 255
- err_o  out  1  at least one digit byte > 9
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result

Behaviour:
- Clock and reset are decided: one clock (clk_i); rst_i is synchronous and active-high.
- Reset values: hex_o=0, n_hex_o=0, ovf_o=0, n_ovf_o=0, err_o=0, valid_o=0. State = IDLE.
- FSM states are IDLE, CONV and DONE.
- IDLE:
  - ready_o=1, valid_o=0. ready_o is combinational from state, so it is high while rst_i is held. valid_i is ignored while rst_i=1.
  - On an edge with valid_i & ready_o: capture dec_i and n_dec_i into internal registers. Clear acc (17 bits) and n_acc (10 bits). Set idx=4 and go to CONV.
- CONV:
  - ready_o=0, valid_o=0.
  - Each edge: acc <= acc*10 + dig[idx].
  - When idx<=2: n_acc <= n_acc*10 + n_dig[idx].
  - Any captured byte > 9 (including nonzero [7:4]) sets the internal err flag.
  - idx decrements each edge. On the edge with idx==0, go to DONE and register the outputs.
  - Exactly 5 CONV edges. valid_o rises 5 clocks after the accept edge.
- Output registration, on entry to DONE:
  - If err: hex_o=0, n_hex_o=0, err_o=1, ovf_o=0, n_ovf_o=0.
  - Else if acc > 65535: ovf_o=1; hex_o = SAT_EN ? 16'hFFFF : acc[15:0].
  - Else: hex_o = acc[15:0], ovf_o=0.
  - The count path follows the same rules with threshold 255: n_hex_o = 8'hFF or n_acc[7:0], and n_ovf_o.
- DONE:
  - valid_o=1, ready_o=0.
  - Outputs hold stable while ready_i=0, for any number of cycles.
  - On an edge with ready_i=1, go to IDLE. valid_o falls and ready_o rises in the next cycle.
  - ready_i high in the first DONE cycle gives a one-cycle transfer.
- Result outputs hold their last values after transfer until the next DONE entry. They do not clear in IDLE.
- No overlap: a new word is accepted only in IDLE, so minimum throughput is one word per 7 clocks.
- Reset mid-CONV or mid-DONE: the next state is IDLE, all outputs take their reset values, and the partial result is discarded. No valid_o is produced for the aborted word.
- Digit width rule: the full 8-bit byte is checked against 9. The multiply-add uses dig[3:0] only.
- Arithmetic widths:
  - Maximum acc = 99999, fits 17 bits.
  - Maximum n_acc = 999, fits 10 bits.
  - No intermediate truncation.

Test Plan:
- Basic conversion: dec_i={1,2,3,4,5}, n_dec_i={0,4,2}, ready_i=1 -> hex_o=16'h3039, n_hex_o=8'h2A, flags 0. valid_o high exactly 5 clocks after accept, for 1 cycle. ready_o low for 6 cycles.
- Boundaries:
  - {6,5,5,3,5} -> 16'hFFFF, ovf_o=0.
  - {6,5,5,3,6} -> ovf_o=1, hex_o=16'hFFFF with SAT_EN=1; hex_o=16'h0000 with SAT_EN=0.
  - n {2,5,5} -> 8'hFF, n_ovf_o=0.
  - n {9,9,9} -> n_ovf_o=1, n_hex_o=8'hFF with SAT_EN=1; n_hex_o=8'hE7 with SAT_EN=0.
- Invalid digit: dec_i[2]=8'h0A (or 8'h13) -> err_o=1, hex_o=0, n_hex_o=0, ovf_o=0.
- Backpressure: ready_i=0 for 4 cycles after valid_o rises -> outputs and valid_o stable. valid_i asserted during DONE is not accepted. Accept happens only after return to IDLE.
- Reset: assert rst_i for 1 cycle on the 3rd CONV edge -> all outputs 0, ready_o=1, no valid_o. A following word {0,0,0,0,7} / {0,0,1} yields 16'h0007 / 8'h01.
- Round trip: 1000 random 16-bit values and 8-bit counts split into decimal digits, fed back through dec_to_hex -> result equals the original, all flags 0.
